// File: rtl/add_seq.sv
// ---------------------------------------------------------------------------
// add_seq : multi-word add/subtract sequencer.
//
// Performs a WORDS*BUS_WIDTH-bit a+b or a-b using one BUS_WIDTH-bit adder,
// one word per clock, least-significant word first. The carry between words
// is held in an internal carry register. Subtraction is a + ~b + 1, where the
// +1 is the initial value of the carry register.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    request a new operation (sampled only while ready=1)
//   sub      0 = a+b, 1 = a-b (sampled with start)
//   a, b     full-width operands (sampled with start)
//   ready    a start will be accepted (IDLE or DONE)
//   busy     operation in progress (RUN)
//   done     one-cycle pulse, sum/carry/overflow valid
//   sum      result register, filled progressively during RUN
//   carry    carry out of the MSW (for sub: 1 = no borrow)
//   overflow two's-complement overflow of the full-width operation
// ---------------------------------------------------------------------------
module add_seq #(
  parameter int BUS_WIDTH = 16,
  parameter int WORDS     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         sub,
  input  logic [WORDS*BUS_WIDTH-1:0]   a,
  input  logic [WORDS*BUS_WIDTH-1:0]   b,
  output logic                         ready,
  output logic                         busy,
  output logic                         done,
  output logic [WORDS*BUS_WIDTH-1:0]   sum,
  output logic                         carry,
  output logic                         overflow
);

  localparam int W  = WORDS * BUS_WIDTH;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [KW-1:0]         k;
  logic                  cy;

  logic [W-1:0]          a_q;
  logic [W-1:0]          b_q;
  logic                  sub_q;

  logic signed [BUS_WIDTH-1:0] aw;
  logic signed [BUS_WIDTH-1:0] bw_raw;
  logic signed [BUS_WIDTH-1:0] bw;
  logic signed [BUS_WIDTH-1:0] sw;
  logic                        cout;
  logic                        ovf;
  logic                        last;

  // One word of the shared adder: returns {carry_out, sum_word}.
  function automatic logic [BUS_WIDTH:0] add_word(
    input logic [BUS_WIDTH-1:0] x,
    input logic [BUS_WIDTH-1:0] y,
    input logic                 cin
  );
    add_word = {1'b0, x} + {1'b0, y} + {{BUS_WIDTH{1'b0}}, cin};
  endfunction

  // Signed overflow of the MSW: operands agree in sign but the result does not.
  // This equals carry-into-MSB XOR carry-out-of-MSB on the effective b.
  function automatic logic ovf_word(
    input logic signed [BUS_WIDTH-1:0] x,
    input logic signed [BUS_WIDTH-1:0] y,
    input logic signed [BUS_WIDTH-1:0] s
  );
    ovf_word = ((x < 0) == (y < 0)) && ((s < 0) != (x < 0));
  endfunction

  // Word select and single-word add for the current index k.
  always_comb begin
    aw     = '0;
    bw_raw = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (k == KW'(i)) begin
        aw     = a_q[i*BUS_WIDTH +: BUS_WIDTH];
        bw_raw = b_q[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
    bw         = sub_q ? ~bw_raw : bw_raw;
    {cout, sw} = add_word(aw, bw, cy);
    ovf        = ovf_word(aw, bw, sw);
    last       = (k == KW'(WORDS - 1));
  end

  // Operand capture at acceptance; data path only, no reset needed because
  // the state machine never consumes these before a fresh capture.
  always_ff @(posedge clk) begin
    if (ready && start) begin
      a_q   <= a;
      b_q   <= b;
      sub_q <= sub;
    end
  end

  // Sequencer: control, carry chain and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      cy       <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ready    <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            cy    <= sub;
            k     <= '0;
            busy  <= 1'b1;
            ready <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (k == KW'(i)) sum[i*BUS_WIDTH +: BUS_WIDTH] <= sw;
          end
          cy <= cout;
          if (last) begin
            carry    <= cout;
            overflow <= ovf;
            state    <= DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            ready    <= 1'b1;
          end else begin
            k <= k + KW'(1);
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/add_seq.md
Name: add_seq

Overview:
- Multi-word add/subtract sequencer. It performs a WORDS*BUS_WIDTH-bit addition or subtraction one BUS_WIDTH-bit word per clock, least-significant word first, and carries between words through an internal carry register.
- It lets the CPU perform wide arithmetic (64-bit at defaults) with a single 16-bit adder datapath.
- It sits between the control unit (start/done handshake) and the ALU adder.

Parameters:
- BUS_WIDTH, 16, width of one word / of the shared adder.
- WORDS, 4, number of words per operand (>= 1); full operand width W = WORDS*BUS_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a new operation; sampled only when ready=1.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  W  first operand; sampled with start.
- b  input  W  second operand; sampled with start.
- ready  output  1  1 when a start will be accepted (IDLE or DONE).
- busy  output  1  1 while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  W  result register.
- carry  output  1  final carry out of the MSW; for sub, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow of the full-width operation.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All registers update on the rising edge of clk.
- Reset values: state=IDLE, sum=0, carry=0, overflow=0, done=0, busy=0, ready=1, word index=0, carry register=0.
- States:
  - IDLE: ready=1. If start=1, latch a, b, sub; set carry register=sub; set word index k=0; go to RUN.
  - RUN: busy=1, ready=0. Each edge computes word k = a[k] + (sub ? ~b[k] : b[k]) + carry register. The word is written into sum[k*BUS_WIDTH +: BUS_WIDTH] and the carry register updates.
    - k=WORDS-1: also write carry and overflow, then go to DONE.
    - Otherwise: k increments.
  - DONE: done=1, ready=1, busy=0, for exactly one cycle. If start=1, behave exactly as IDLE accepting it (back-to-back, no bubble); otherwise go to IDLE.
- Latency: start sampled at edge t → word k written at edge t+1+k → done=1 during the cycle following edge t+WORDS. Throughput is one operation per WORDS+1 cycles.
- Operand capture: a, b, sub are captured at acceptance. Later changes to the inputs do not affect the running operation.
- start while busy=1 is ignored, not queued.
- sum visibility:
  - sum holds the previous result in IDLE and DONE.
  - During RUN, low words update progressively: words < k hold new values, words >= k hold old values.
  - Consumers sample only when done=1.
- carry, overflow: hold their previous values until the final RUN edge, then update simultaneously with the MSW.
- overflow = carry into MSB XOR carry out of MSB, computed on the effective (possibly inverted) b.
- Arithmetic: modulo 2^W. Subtraction is a + ~b + 1, the +1 coming from the initial carry register = sub.
- WORDS=1: RUN lasts exactly one edge; done follows.
- rst at any point, including mid-RUN or coincident with start or done:
  - Forces reset values on that edge.
  - The in-flight operation is aborted with no done pulse.
  - The start presented in the reset cycle is discarded.

Test Plan:
- Reset: assert rst 2 cycles with start=1 → sum=0, carry=0, overflow=0, done=0, busy=0, ready=1; no operation begins.
- Basic add (defaults): a=5, b=5, start 1 cycle → busy=1 for 4 cycles, then done=1 for 1 cycle with sum=10, carry=0, overflow=0; ready low during busy.
- Carry chain: a=0x0000_0000_0000_FFFF, b=1 → sum=0x0000_0000_0001_0000. Then a=0xFFFF_FFFF_FFFF_FFFF, b=1 → sum=0, carry=1, overflow=0. Then a=0x7FFF_FFFF_FFFF_FFFF, b=1 → sum=0x8000_0000_0000_0000, overflow=1, carry=0.
- Subtract: a=0, b=1, sub=1 → sum=0xFFFF_FFFF_FFFF_FFFF, carry=0. Then a=300, b=44, sub=1 → sum=256, carry=1, overflow=0. Then a=0x8000_0000_0000_0000, b=1, sub=1 → overflow=1.
- Handshake: start pulsed again during RUN with different operands → ignored, result matches the first operation. start held in the DONE cycle with a=1, b=2 → accepted with no idle cycle; next done shows sum=3.
- Abort: start a=65535, b=65535, then assert rst on the 2nd RUN edge → all outputs return to reset values next cycle, and no done pulse occurs in the following 10 cycles.
